// File: rtl/seg_msg_scheduler.sv
// Front-end for the four-digit seven-segment driver: round-robin loads a message
// from one of two byte streams, then shows it statically or as a scrolling ring.
module seg_msg_scheduler #(
    parameter int         MSG_DEPTH  = 16,
    parameter int         SCROLL_DIV = 25000000,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       src0_valid,
    input  logic [7:0] src0_data,
    input  logic       src0_last,
    output logic       src0_ready,
    input  logic       src1_valid,
    input  logic [7:0] src1_data,
    input  logic       src1_last,
    output logic       src1_ready,
    input  logic       clear,
    output logic [7:0] char0,
    output logic [7:0] char1,
    output logic [7:0] char2,
    output logic [7:0] char3,
    output logic [1:0] grant,
    output logic       busy,
    output logic       overflow
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = $clog2(MSG_DEPTH + 8);
    localparam int CW = $clog2(SCROLL_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    msg_buf [MSG_DEPTH];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] len;
    logic [PW-1:0] pos;
    logic [PW-1:0] ring_len;
    logic [PW-1:0] idx;
    logic [CW-1:0] scroll_cnt;
    logic          prefer1;

    logic          arb_req;
    logic          arb_pick1;
    logic [1:0]    grant_nxt;
    logic          acc;
    logic          acc_last;
    logic [7:0]    acc_data;
    logic          buf_full;
    logic          wr_en;
    logic          load_done;
    logic          scrolling;
    logic          scroll_tick;
    logic          showing;
    logic [7:0]    disp [4];
    logic [7:0]    char_nxt [4];
    logic          busy_nxt;
    logic          ready0_nxt;
    logic          ready1_nxt;

    always_comb begin
        acc      = 1'b0;
        acc_data = src0_data;
        acc_last = src0_last;
        if (state == LOAD) begin
            if (grant[1]) begin
                acc      = src1_valid & src1_ready;
                acc_data = src1_data;
                acc_last = src1_last;
            end else begin
                acc      = src0_valid & src0_ready;
            end
        end
    end

    // Bytes beyond the buffer are still handshaken but only flag overflow.
    assign buf_full    = (wr_ptr == LW'(MSG_DEPTH));
    assign wr_en       = acc && !clear && !buf_full;
    assign load_done   = acc && acc_last && !clear;
    assign arb_req     = (state != LOAD) && !clear && (src0_valid || src1_valid);
    assign arb_pick1   = src1_valid && (!src0_valid || prefer1);
    assign grant_nxt   = arb_req ? (arb_pick1 ? 2'b10 : 2'b01) : grant;
    assign ring_len    = PW'(len) + PW'(4);
    assign scrolling   = (len > LW'(4));
    assign scroll_tick = (scroll_cnt == CW'(SCROLL_DIV - 1));
    assign showing     = (state == SHOW) && (state_nxt == SHOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (arb_req) state_nxt = LOAD;
                LOAD:    if (load_done) state_nxt = SHOW;
                SHOW:    if (arb_req) state_nxt = LOAD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Four-character window into the ring of message plus four blanks; with
    // len <= 4 and pos = 0 this reduces to the left-justified static view.
    always_comb begin
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            idx = pos + PW'(k);
            if (idx >= ring_len) idx = idx - ring_len;
            disp[3-k] = (idx < PW'(len)) ? msg_buf[idx[AW-1:0]] : BLANK_CHAR;
        end
    end

    always_comb begin
        busy_nxt   = (state_nxt == LOAD);
        ready0_nxt = busy_nxt && grant_nxt[0];
        ready1_nxt = busy_nxt && grant_nxt[1];
        for (int k = 0; k < 4; k++) begin
            char_nxt[k] = showing ? disp[k] : BLANK_CHAR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 2'b00;
            busy       <= 1'b0;
            src0_ready <= 1'b0;
            src1_ready <= 1'b0;
            char0      <= BLANK_CHAR;
            char1      <= BLANK_CHAR;
            char2      <= BLANK_CHAR;
            char3      <= BLANK_CHAR;
        end else begin
            grant      <= grant_nxt;
            busy       <= busy_nxt;
            src0_ready <= ready0_nxt;
            src1_ready <= ready1_nxt;
            char0      <= char_nxt[0];
            char1      <= char_nxt[1];
            char2      <= char_nxt[2];
            char3      <= char_nxt[3];
        end
    end

    // Load bookkeeping and scroll timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer1    <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            len        <= '0;
            pos        <= '0;
            scroll_cnt <= '0;
        end else if (arb_req) begin
            prefer1  <= !arb_pick1;
            overflow <= 1'b0;
            wr_ptr   <= '0;
        end else if (acc && !clear) begin
            if (buf_full) begin
                overflow <= 1'b1;
            end else begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (acc_last) begin
                len        <= buf_full ? LW'(MSG_DEPTH) : wr_ptr + LW'(1);
                pos        <= '0;
                scroll_cnt <= '0;
            end
        end else if (showing && scrolling) begin
            if (scroll_tick) begin
                scroll_cnt <= '0;
                pos        <= (pos == ring_len - PW'(1)) ? '0 : pos + PW'(1);
            end else begin
                scroll_cnt <= scroll_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            msg_buf[wr_ptr[AW-1:0]] <= acc_data;
        end
    end

endmodule

// File: tb/tb_seg_msg_scheduler.sv
// Directed bench for seg_msg_scheduler: static and scrolling display, round-robin,
// overflow, clear and asynchronous reset, with hand-computed expected characters.
module tb_seg_msg_scheduler;

    logic       clk;
    logic       rst_n;
    logic       src0_valid;
    logic [7:0] src0_data;
    logic       src0_last;
    logic       src0_ready;
    logic       src1_valid;
    logic [7:0] src1_data;
    logic       src1_last;
    logic       src1_ready;
    logic       clear;
    logic [7:0] char0;
    logic [7:0] char1;
    logic [7:0] char2;
    logic [7:0] char3;
    logic [1:0] grant;
    logic       busy;
    logic       overflow;
    logic [31:0] shown;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    seg_msg_scheduler #(
        .MSG_DEPTH (16),
        .SCROLL_DIV(4),
        .BLANK_CHAR(8'h20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src0_valid(src0_valid),
        .src0_data (src0_data),
        .src0_last (src0_last),
        .src0_ready(src0_ready),
        .src1_valid(src1_valid),
        .src1_data (src1_data),
        .src1_last (src1_last),
        .src1_ready(src1_ready),
        .clear     (clear),
        .char0     (char0),
        .char1     (char1),
        .char2     (char2),
        .char3     (char3),
        .grant     (grant),
        .busy      (busy),
        .overflow  (overflow)
    );

    assign shown = {char3, char2, char1, char0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveSrc(input int src, input logic v, input logic [7:0] d, input logic l);
        if (src == 0) begin
            src0_valid = v;
            src0_data  = d;
            src0_last  = l;
        end else begin
            src1_valid = v;
            src1_data  = d;
            src1_last  = l;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the final byte is taken.
    task automatic applyStimulus(input int src, input string msg, input bit endMsg);
        int         waitN;
        logic [7:0] ch;
        for (int i = 0; i < msg.len(); i++) begin
            ch = msg[i];
            driveSrc(src, 1'b1, ch, endMsg && (i == msg.len() - 1));
            waitN = 0;
            while (((src == 0) ? src0_ready : src1_ready) !== 1'b1 && waitN < 50) begin
                @(negedge clk);
                waitN++;
            end
            checkOutput("ready_wait", (waitN < 50) ? 32'd1 : 32'd0, 32'd1);
            checkOutput("other_ready", {31'd0, (src == 0) ? src1_ready : src0_ready}, 32'd0);
            @(negedge clk);
        end
        driveSrc(src, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        driveSrc(0, 1'b0, 8'h00, 1'b0);
        driveSrc(1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_chars", shown, "    ");
        checkOutput("rst_grant", {30'd0, grant}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("rst_ready", {30'd0, src1_ready, src0_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] static message AB from src0");
        applyStimulus(0, "AB", 1'b1);
        checkOutput("ab_before_visible", shown, "    ");
        checkOutput("ab_grant", {30'd0, grant}, 32'd1);
        checkOutput("ab_busy_done", {31'd0, busy}, 32'd0);
        checkOutput("ab_ready_done", {31'd0, src0_ready}, 32'd0);
        @(negedge clk);
        checkOutput("ab_chars", shown, "AB  ");

        $display("[TB] scrolling HELLO! from src1");
        applyStimulus(1, "HELLO!", 1'b1);
        checkOutput("hello_grant", {30'd0, grant}, 32'd2);
        @(negedge clk);
        checkOutput("hello_pos0", shown, "HELL");
        repeat (3) @(negedge clk);
        checkOutput("hello_pos0_end", shown, "HELL");
        @(negedge clk);
        checkOutput("hello_pos1", shown, "ELLO");
        repeat (8) @(negedge clk);
        checkOutput("hello_pos3", shown, "LO! ");
        repeat (12) @(negedge clk);
        checkOutput("hello_pos6", shown, "    ");
        repeat (12) @(negedge clk);
        checkOutput("hello_pos9", shown, " HEL");
        repeat (3) @(negedge clk);
        checkOutput("hello_pos9_end", shown, " HEL");
        @(negedge clk);
        checkOutput("hello_wrap", shown, "HELL");

        $display("[TB] 20-byte message overflows 16-entry buffer");
        applyStimulus(0, "ABCDEFGHIJKLMNOPQRST", 1'b1);
        checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
        checkOutput("ovf_grant", {30'd0, grant}, 32'd1);
        @(negedge clk);
        checkOutput("ovf_pos0", shown, "ABCD");
        repeat (4) @(negedge clk);
        checkOutput("ovf_pos1", shown, "BCDE");
        repeat (48) @(negedge clk);
        checkOutput("ovf_pos13", shown, "NOP ");
        repeat (16) @(negedge clk);
        checkOutput("ovf_pos17", shown, "   A");
        repeat (8) @(negedge clk);
        checkOutput("ovf_pos19", shown, " ABC");
        repeat (4) @(negedge clk);
        checkOutput("ovf_wrap", shown, "ABCD");
        @(negedge clk);

        $display("[TB] asynchronous reset mid-scroll");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_chars", shown, "    ");
        checkOutput("arst_grant", {30'd0, grant}, 32'd0);
        checkOutput("arst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] both sources request after reset");
        driveSrc(1, 1'b1, 8'h59, 1'b1);
        applyStimulus(0, "XY", 1'b1);
        checkOutput("both_grant0", {30'd0, grant}, 32'd1);
        checkOutput("both_ready1_idle", {31'd0, src1_ready}, 32'd0);
        @(negedge clk);
        checkOutput("both_grant1", {30'd0, grant}, 32'd2);
        checkOutput("both_busy", {31'd0, busy}, 32'd1);
        checkOutput("both_ready1", {31'd0, src1_ready}, 32'd1);
        checkOutput("both_preempt_blank", shown, "    ");
        applyStimulus(1, "Y", 1'b1);
        @(negedge clk);
        checkOutput("both_chars", shown, "Y   ");

        $display("[TB] clear during load");
        applyStimulus(0, "PQR", 1'b0);
        checkOutput("clr_loading_ready", {31'd0, src0_ready}, 32'd1);
        checkOutput("clr_loading_busy", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clr_chars", shown, "    ");
        checkOutput("clr_ready", {30'd0, src1_ready, src0_ready}, 32'd0);
        checkOutput("clr_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1, "MN", 1'b1);
        @(negedge clk);
        checkOutput("clr_reload_chars", shown, "MN  ");
        checkOutput("clr_reload_grant", {30'd0, grant}, 32'd2);

        $display("[TB] clear wins over a new request");
        driveSrc(0, 1'b1, 8'h5A, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        driveSrc(0, 1'b0, 8'h00, 1'b0);
        checkOutput("clrarb_chars", shown, "    ");
        checkOutput("clrarb_busy", {31'd0, busy}, 32'd0);
        checkOutput("clrarb_ready", {31'd0, src0_ready}, 32'd0);
        checkOutput("clrarb_grant", {30'd0, grant}, 32'd2);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_msg_scheduler.md
Name: seg_msg_scheduler

Overview:
- Controller in front of the four-digit seven-segment driver.
- Arbitrates two byte-stream message sources round-robin and stores the granted message in a local buffer.
- Drives the driver's four 8-bit character inputs: static text for short messages, right-to-left scrolling text for long ones.
- All outputs are registered.

Parameters:
MSG_DEPTH, 16, message buffer capacity in characters (power of two, >=8)
SCROLL_DIV, 25000000, clk cycles per scroll step (>=2)
BLANK_CHAR, 8'h20, code placed on unused or padding digits

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
src0_valid  in  1  source 0 byte valid
src0_data  in  8  source 0 character
src0_last  in  1  source 0 final byte of message
src0_ready  out  1  source 0 byte accepted when valid&ready
src1_valid  in  1  source 1 byte valid
src1_data  in  8  source 1 character
src1_last  in  1  source 1 final byte of message
src1_ready  out  1  source 1 byte accepted when valid&ready
clear  in  1  synchronous pulse: blank display, return to IDLE
char0  out  8  rightmost digit character
char1  out  8  digit 1
char2  out  8  digit 2
char3  out  8  leftmost digit character
grant  out  2  one-hot owner of current/last load (2'b00 after reset)
busy  out  1  high in LOAD
overflow  out  1  sticky: last message exceeded MSG_DEPTH

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - char0..char3 = BLANK_CHAR; grant = 0; busy = 0; overflow = 0; readies = 0.
  - Length, position and scroll counter = 0; round-robin pointer favours src0.
- States: IDLE, LOAD, SHOW.
- Arbitration (evaluated in IDLE and SHOW):
  - If exactly one srcN_valid is high, that source wins.
  - If both are high, the source not granted last wins (src0 after reset).
  - Winner is latched into grant; next state LOAD; busy = 1; overflow cleared.
  - Arbitration from SHOW preempts the displayed message.
- Entering LOAD: char0..char3 = BLANK_CHAR; write pointer = 0.
- In LOAD:
  - Only the granted source's ready = 1; the other's ready = 0.
  - Each accepted byte is written to buf[wr_ptr]; wr_ptr increments, saturating at MSG_DEPTH.
  - Bytes accepted while wr_ptr == MSG_DEPTH are discarded and set overflow = 1.
  - An accepted byte with last = 1 ends the load: len = min(count including that byte, MSG_DEPTH); next state SHOW; busy = 0; pos = 0; scroll counter = 0.
  - Grant is held for the whole message; no preemption inside LOAD.
- In SHOW:
  - Static display, len <= 4 (left-justified):
    - char3 = buf[0], char2 = buf[1], char1 = buf[2], char0 = buf[3].
    - Digits with index >= len show BLANK_CHAR.
    - pos stays 0.
  - Scrolling display, len > 4:
    - Virtual ring R of length L = len + 4: R[i] = buf[i] for i < len, BLANK_CHAR otherwise.
    - char3 = R[pos], char2 = R[(pos+1) mod L], char1 = R[(pos+2) mod L], char0 = R[(pos+3) mod L].
    - Scroll counter counts 0..SCROLL_DIV-1; on its terminal count pos increments, and pos = L-1 wraps to 0.
- Latency:
  - Outputs update on the clock edge after the state, pos or buffer change.
  - A message of len <= 4 is visible 1 cycle after its last byte is accepted.
- clear:
  - clear = 1 in any state forces IDLE next cycle, with chars blank and readies 0.
  - An in-flight LOAD is abandoned; overflow is kept.
  - clear has priority over arbitration in the same cycle.
- Simultaneous events:
  - Valid from the non-granted source during LOAD is ignored until the next arbitration.
  - The last byte and a new request in the same cycle: SHOW is entered first; arbitration occurs the following cycle.
- Zero-length messages cannot occur (last always accompanies a byte).

Test Plan:
- Reset, then src0 sends "AB" with last on 'B' -> src0_ready = 1 for 2 accepts; next cycle char3 = 8'h41, char2 = 8'h42, char1 = char0 = 8'h20; grant = 2'b01.
- SCROLL_DIV = 4; src1 sends "HELLO!" (len 6, L = 10) -> pos steps every 4 cycles.
  - pos 0: chars3..0 = "HELL".
  - pos 3: chars3..0 = "LO! ".
  - pos 9: chars3..0 = " HEL".
  - Then wraps to pos 0.
- Both sources valid in IDLE after reset -> src0 granted, src1_ready = 0 throughout.
  - After src0's last, src1 is granted next cycle (preempting SHOW); grant = 2'b10.
- MSG_DEPTH = 16; send 20 bytes with last on 20th -> all 20 accepted; len = 16; overflow = 1; display scrolls bytes 0-15 with L = 20.
- clear asserted mid-LOAD after 3 bytes -> next cycle state IDLE, chars all 8'h20, readies 0.
  - A subsequent message loads from buf[0].
- rst_n pulled low asynchronously mid-scroll (not on a clock edge) -> outputs return immediately to reset values; overflow = 0, grant = 0.
